// File: rtl/seq_step_arbiter_pkg.sv
// seq_step_arbiter_pkg: step codes, stepper walk order and arbiter state encoding
package seq_step_arbiter_pkg;
  localparam logic [2:0] C0 = 3'd0;
  localparam logic [2:0] C3 = 3'd3;
  localparam logic [2:0] C6 = 3'd6;
  localparam logic [2:0] C1 = 3'd1;
  localparam logic [2:0] C5 = 3'd5;
  localparam logic [2:0] C7 = 3'd7;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [2:0] next_code(input logic [2:0] c);
    return c == C0 ? C3 : c == C3 ? C6 : c == C6 ? C1 : c == C1 ? C5 : c == C5 ? C7 : C0;
  endfunction
  function automatic logic illegal_code(input logic [2:0] c);
    return c == 3'd2 || c == 3'd4;
  endfunction
endpackage

// File: rtl/seq_step_arbiter_stepper.sv
// seq_step_arbiter_stepper: 3-bit code register walking 0->3->6->1->5->7
module seq_step_arbiter_stepper
  import seq_step_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       advance,
  output logic [2:0] code
);
  always_ff @(posedge clk)
    code <= !reset || clear ? C0 : advance ? next_code(code) : code;
endmodule

// File: rtl/seq_step_arbiter.sv
// seq_step_arbiter: round-robin ownership of one sequence stepper for a full walk
module seq_step_arbiter
  import seq_step_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            abort,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic [2:0]      step_code,
  output logic            step_valid,
  output logic            hit,
  output logic            done
);
  state_t state;
  logic [PTR_W-1:0] ptr, win, pick;
  logic found, quit, advance;
  // gnt is onehot(win) in RUN, so masking req with it reads the owner's request
  assign quit = abort || (req & gnt) == '0 || illegal_code(step_code);
  assign advance = state == RUN && !quit;
  assign hit = step_valid & step_code[2] & step_code[0];
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      int k;
      k = (int'(ptr) + i) % NREQ;
      if (!found && ((req >> k) & NREQ'(1)) != '0) begin
        pick = PTR_W'(k);
        found = 1'b1;
      end
    end
  end
  seq_step_arbiter_stepper u_stepper (
    .clk(clk),
    .reset(reset),
    .clear(!advance),
    .advance(advance),
    .code(step_code)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      gnt <= '0;
      busy <= 1'b0;
      step_valid <= 1'b0;
      done <= 1'b0;
      ptr <= PTR_W'(NREQ - 1);
      win <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (found) begin
            state <= RUN;
            gnt <= NREQ'(1) << pick;
            win <= pick;
            busy <= 1'b1;
            step_valid <= 1'b1;
          end
        end
        RUN: begin
          if (quit || step_code == C7) begin
            state <= quit ? IDLE : DONE;
            done <= !quit;
            gnt <= '0;
            busy <= 1'b0;
            step_valid <= 1'b0;
            ptr <= win;
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_step_arbiter.sv
// tb_seq_step_arbiter: directed scenario checks of grant order, walk, abandon and reset
module tb_seq_step_arbiter;
  logic clk = 0, reset = 0, abort = 0;
  logic [3:0] req = 0, gnt;
  logic busy, step_valid, hit, done;
  logic [2:0] step_code;
  int compared = 0, mismatched = 0;

  seq_step_arbiter #(.NREQ(4), .PTR_W(3)) dut (
    .clk(clk), .reset(reset), .req(req), .abort(abort), .gnt(gnt), .busy(busy),
    .step_code(step_code), .step_valid(step_valid), .hit(hit), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 0; abort = 0; req = 0;
    tick(); tick();
    reset = 1;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    reset = 0; abort = 0; req = 4'b1111;
    tick(); tick();
    obs = {gnt, busy, step_code, step_valid, done};
    compared++;
    if (obs !== 10'd0 || hit !== 1'b0) begin mismatched++; $display("FAIL reset_outputs got=%b hit=%b want=0", obs, hit); end
    reset = 1;
    tick();
    compared++;
    if (gnt !== 4'b0001) begin mismatched++; $display("FAIL reset_first_gnt got=%b want=0001", gnt); end
  endtask

  task automatic test_walk();
    logic [2:0] codes [6] = '{3'd0, 3'd3, 3'd6, 3'd1, 3'd5, 3'd7};
    logic hits [6] = '{0, 0, 0, 0, 1, 1};
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      tick();
      compared++;
      if (step_code !== codes[i] || hit !== hits[i] || step_valid !== 1'b1 || busy !== 1'b1 || gnt !== 4'b0100 || done !== 1'b0) begin
        mismatched++;
        $display("FAIL walk_step%0d code=%0d hit=%b valid=%b busy=%b gnt=%b done=%b want code=%0d hit=%b valid=1 busy=1 gnt=0100 done=0",
                 i, step_code, hit, step_valid, busy, gnt, done, codes[i], hits[i]);
      end
    end
    tick();
    compared++;
    if (done !== 1'b1 || gnt !== 4'b0000 || busy !== 1'b0 || step_valid !== 1'b0 || step_code !== 3'd0) begin
      mismatched++; $display("FAIL walk_done done=%b gnt=%b busy=%b valid=%b code=%0d want 1/0000/0/0/0", done, gnt, busy, step_valid, step_code);
    end
    tick();
    compared++;
    if (done !== 1'b0 || gnt !== 4'b0000) begin mismatched++; $display("FAIL walk_gap done=%b gnt=%b want 0/0000", done, gnt); end
    tick();
    compared++;
    if (gnt !== 4'b0100 || step_code !== 3'd0) begin mismatched++; $display("FAIL walk_regrant gnt=%b code=%0d want 0100/0", gnt, step_code); end
    req = 0;
  endtask

  task automatic test_round_robin();
    logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1111;
    for (int w = 0; w < 5; w++) begin
      tick();
      compared++;
      if (gnt !== order[w]) begin mismatched++; $display("FAIL rr_walk%0d gnt=%b want=%b", w, gnt, order[w]); end
      repeat (5) tick();
      compared++;
      if (step_code !== 3'd7 || gnt !== order[w]) begin mismatched++; $display("FAIL rr_end%0d code=%0d gnt=%b want 7/%b", w, step_code, gnt, order[w]); end
      tick();
      compared++;
      if (done !== 1'b1) begin mismatched++; $display("FAIL rr_done%0d done=%b want=1", w, done); end
      tick();
    end
    req = 0;
  endtask

  task automatic test_abort();
    int pulses = 0;
    do_reset();
    req = 4'b0010;
    repeat (3) tick();
    compared++;
    if (step_code !== 3'd6 || gnt !== 4'b0010) begin mismatched++; $display("FAIL abort_setup code=%0d gnt=%b want 6/0010", step_code, gnt); end
    abort = 1;
    tick();
    abort = 0; req = 0;
    compared++;
    if (gnt !== 4'b0000 || step_code !== 3'd0 || step_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++; $display("FAIL abort_exit gnt=%b code=%0d valid=%b busy=%b done=%b want all 0", gnt, step_code, step_valid, busy, done);
    end
    repeat (8) begin tick(); pulses += int'(done); end
    compared++;
    if (pulses !== 0) begin mismatched++; $display("FAIL abort_no_done pulses=%0d want=0", pulses); end
  endtask

  task automatic test_abort_at_last();
    do_reset();
    req = 4'b1000;
    repeat (6) tick();
    abort = 1;
    tick();
    abort = 0; req = 0;
    compared++;
    if (done !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0) begin mismatched++; $display("FAIL abort_code7 done=%b gnt=%b busy=%b want 0/0000/0", done, gnt, busy); end
  endtask

  task automatic test_drop();
    do_reset();
    req = 4'b1111;
    repeat (4) tick();
    compared++;
    if (step_code !== 3'd1 || gnt !== 4'b0001) begin mismatched++; $display("FAIL drop_setup code=%0d gnt=%b want 1/0001", step_code, gnt); end
    req = 4'b1110;
    tick();
    compared++;
    if (gnt !== 4'b0000 || done !== 1'b0 || step_valid !== 1'b0 || step_code !== 3'd0) begin
      mismatched++; $display("FAIL drop_exit gnt=%b done=%b valid=%b code=%0d want 0000/0/0/0", gnt, done, step_valid, step_code);
    end
    tick();
    compared++;
    if (gnt !== 4'b0010) begin mismatched++; $display("FAIL drop_next gnt=%b want=0010", gnt); end
    req = 0;
  endtask

  task automatic test_reset_mid_walk();
    logic [9:0] obs;
    do_reset();
    req = 4'b0100;
    repeat (5) tick();
    compared++;
    if (step_code !== 3'd5 || hit !== 1'b1) begin mismatched++; $display("FAIL midreset_setup code=%0d hit=%b want 5/1", step_code, hit); end
    reset = 0;
    tick();
    obs = {gnt, busy, step_code, step_valid, done};
    compared++;
    if (obs !== 10'd0 || hit !== 1'b0) begin mismatched++; $display("FAIL midreset_outputs got=%b hit=%b want=0", obs, hit); end
    reset = 1; req = 4'b1111;
    tick();
    compared++;
    if (gnt !== 4'b0001) begin mismatched++; $display("FAIL midreset_ptr gnt=%b want=0001", gnt); end
    req = 0;
  endtask

  initial begin
    test_reset();
    test_walk();
    test_round_robin();
    test_abort();
    test_abort_at_last();
    test_drop();
    test_reset_mid_walk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
